// File: rtl/scaled_clock_bank.sv
// scaled_clock_bank: NUM_CH independent 50%-duty clock dividers running off inclk.
// Each channel has its own enable and a runtime-loadable half-period. New divisors
// take effect only at the end of a full output period, so no period is ever cut short
// or stretched. sync_all restarts every channel in phase.
module scaled_clock_bank #(
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned CNT_W      = 26,
   parameter int unsigned DEFAULT_HP = 50000000
) (
   input  logic                    inclk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       ena,
   input  logic                    sync_all,
   input  logic [NUM_CH*CNT_W-1:0] div_val,
   input  logic [NUM_CH-1:0]       div_load,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       pend
);

   localparam logic [CNT_W-1:0] HP_RST = CNT_W'(DEFAULT_HP);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [CNT_W-1:0] count;
      logic [CNT_W-1:0] hp;
      logic [CNT_W-1:0] pv;
      logic [CNT_W-1:0] slice;
      logic [CNT_W-1:0] hp_m1;
      logic             boundary;
      logic             co;
      logic             tk;
      logic             pd;

      // Decode this channel's divisor slice and the terminal-count compare.
      // A zero half-period behaves as one, so hp_eff-1 is zero in both cases.
      always_comb begin
         slice    = div_val[g*CNT_W +: CNT_W];
         hp_m1    = (hp == '0) ? '0 : hp - ONE;
         boundary = (count == hp_m1);
      end

      // Divider state: restart on sync/disable, toggle at terminal count,
      // and swap in a pending divisor only at the falling (end-of-period) boundary.
      always_ff @(posedge inclk) begin
         if (rst) begin
            count <= '0;
            hp    <= HP_RST;
            pv    <= '0;
            co    <= 1'b0;
            tk    <= 1'b0;
            pd    <= 1'b0;
         end else if (sync_all || !ena[g]) begin
            count <= '0;
            co    <= 1'b0;
            tk    <= 1'b0;
            pd    <= 1'b0;
            if (div_load[g]) begin
               hp <= slice;
            end else if (pd) begin
               hp <= pv;
            end
         end else if (boundary) begin
            count <= '0;
            co    <= ~co;
            tk    <= ~co;
            if (co) begin
               // End of a full period: a load in this very cycle bypasses pv.
               pd <= 1'b0;
               if (div_load[g]) begin
                  hp <= slice;
               end else if (pd) begin
                  hp <= pv;
               end
            end else if (div_load[g]) begin
               pv <= slice;
               pd <= 1'b1;
            end
         end else begin
            count <= count + ONE;
            tk    <= 1'b0;
            if (div_load[g]) begin
               pv <= slice;
               pd <= 1'b1;
            end
         end
      end

      assign clk_out[g] = co;
      assign tick[g]    = tk;
      assign pend[g]    = pd;
   end

endmodule
